spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter: MAX_ADDR, 4, highest writable register address; addresses above it are ignored.
REQ-002 Clocking: single clock domain, clk; reset is rst, synchronous, active-high.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 sclk  input  1  SPI serial clock, asynchronous to clk, mode 0.
REQ-006 copi  input  1  SPI controller-out data, asynchronous.
REQ-007 ncs  input  1  SPI chip select, active-low, asynchronous.
REQ-008 cipo  output  1  SPI controller-in data; readback only.
REQ-009 en_reg_out_7_0 / en_reg_out_15_8  output  8 each  output-enable registers for PWM peripheral, address 0x00 / 0x01.
REQ-010 en_reg_pwm_7_0 / en_reg_pwm_15_8  output  8 each  PWM-mode enable registers, address 0x02 / 0x03.
REQ-011 pwm_duty_cycle  output  8  duty-cycle register, address 0x04.
REQ-012 wr_done  output  1  one-cycle pulse on each accepted register write.
REQ-013 frame_err  output  1  one-cycle pulse on each discarded frame.

Function
REQ-014 sclk, copi, ncs SHALL each pass a 2-flop synchronizer plus one history flop; edges detected on synchronized values only.
REQ-015 Supported sclk frequency SHALL be at most clk/8; behaviour above that is undefined.
REQ-016 Frame: 16 bits MSB-first; bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
REQ-017 FSM states: IDLE, SHIFT, COMMIT.
REQ-018 IDLE -> SHIFT on synchronized ncs falling edge; bit counter cleared to 0.
REQ-019 SHIFT: each synchronized sclk rising edge shifts copi into shift register LSB, counter increments, saturating at 17.
REQ-020 SHIFT -> COMMIT on ncs rising edge with counter == 16; any other count -> IDLE with frame_err pulse, no register change.
REQ-021 COMMIT lasts exactly one cycle then -> IDLE.
REQ-022 COMMIT with R/W=1 and address <= MAX_ADDR: addressed register loads data; wr_done pulses in the same cycle; new value visible on outputs the cycle after COMMIT.
REQ-023 COMMIT with address > MAX_ADDR or R/W=0: no register change, no wr_done, no frame_err.
REQ-024 sclk edges while in IDLE or COMMIT SHALL be ignored.
REQ-025 ncs low when rst deasserts: no frame starts until ncs goes high then low again.
REQ-026 Register outputs hold their value except on an accepted write or reset.

Reset
REQ-027 rst SHALL force FSM to IDLE, counter and shift register to 0, all five registers to 0x00, cipo, wr_done, frame_err to 0.
REQ-028 rst asserted mid-frame SHALL abort the frame; remaining bits of that frame are ignored.
REQ-029 Synchronizer flops SHALL reset to idle bus levels: ncs 1, sclk 0, copi 0.

Configuration
REQ-030 Macro SPI_READBACK_EN: when defined, R/W=0 frames return data on cipo.
REQ-031 With SPI_READBACK_EN: after the 8th sclk rising edge, the addressed register value (0x00 if address > MAX_ADDR) loads an output shifter; cipo updates MSB-first on each of the following synchronized sclk falling edges; cipo returns to 0 when ncs rises.
REQ-032 Without SPI_READBACK_EN: cipo SHALL be constant 0; R/W=0 frames still validated per REQ-020 and REQ-023.

Verification
REQ-033 Write 0x80FF (addr 0x00, data 0xFF) -> en_reg_out_7_0 = 0xFF, one wr_done pulse, other registers unchanged at 0x00.
REQ-034 Write 0x8480 (addr 0x04, data 0x80) -> pwm_duty_cycle = 0x80 one cycle after COMMIT.
REQ-035 Write 0x85AA (addr 0x05) -> no register change, no wr_done, no frame_err.
REQ-036 Frame with 15 or with 17 sclk edges, data 0x80FF -> frame_err pulse, en_reg_out_7_0 remains 0x00.
REQ-037 rst asserted after 10 bits of 0x8355, then ncs high and full write of 0x8333 -> en_reg_pwm_15_8 = 0x33, no partial write from the aborted frame.
REQ-038 SPI_READBACK_EN defined, write 0x8480 then read 0x04xx -> cipo shifts 0x80 during bits 8-15; with macro undefined cipo stays 0.

Source files
------------

// File: rtl/spi_reg_ctrl.sv
// SPI-mode-0 slave exposing five 8-bit control registers for a PWM peripheral.
// Define SPI_READBACK_EN to return register contents on cipo during R/W=0 frames.
module spi_reg_ctrl #(
  parameter int MAX_ADDR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic       cipo,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_done,
  output logic       frame_err
);

  localparam logic [6:0] MAX_A = 7'(MAX_ADDR);

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state_reg, state_next;
  logic [2:0]  sclk_sync_reg, copi_sync_reg, ncs_sync_reg;
  logic [1:0]  settle_reg;
  logic        armed_reg;
  logic [4:0]  cnt_reg, cnt_next;
  logic [15:0] shift_reg, shift_next;
  logic [7:0]  reg_vals [5];
  logic [6:0]  wr_addr;
  logic        sclk_rise, ncs_fall, ncs_rise, copi_bit;

  // Bit [1] is the synchronized level, bit [2] its one-cycle history.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_reg <= 3'b000;
      copi_sync_reg <= 3'b000;
      ncs_sync_reg  <= 3'b111;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[1:0], sclk};
      copi_sync_reg <= {copi_sync_reg[1:0], copi};
      ncs_sync_reg  <= {ncs_sync_reg[1:0], ncs};
    end
  end

  assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
  assign ncs_fall  = ~ncs_sync_reg[1] & ncs_sync_reg[2];
  assign ncs_rise  = ncs_sync_reg[1] & ~ncs_sync_reg[2];
  // copi as it stood just before the detected sclk rise
  assign copi_bit  = copi_sync_reg[2];
  assign wr_addr   = shift_reg[14:8];

  // A frame may only start once ncs has genuinely been seen high after reset;
  // settle_reg waits out the reset values still draining from the synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_reg <= 2'b00;
      armed_reg  <= 1'b0;
    end else begin
      settle_reg <= {settle_reg[0], 1'b1};
      if (settle_reg[1] && ncs_sync_reg[1]) armed_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      shift_reg <= shift_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    shift_next = shift_reg;
    wr_done    = 1'b0;
    frame_err  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (armed_reg && ncs_fall) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (ncs_rise) begin
          if (cnt_reg == 5'd16) begin
            state_next = COMMIT;
          end else begin
            state_next = IDLE;
            frame_err  = 1'b1;
          end
        end else if (sclk_rise) begin
          shift_next = {shift_reg[14:0], copi_bit};
          if (cnt_reg != 5'd17) cnt_next = cnt_reg + 5'd1;
        end
      end
      COMMIT: begin
        state_next = IDLE;
        wr_done    = shift_reg[15] && (wr_addr <= MAX_A);
      end
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi++) begin : g_reg
      logic [7:0] q_reg;
      always_ff @(posedge clk) begin
        if (rst) q_reg <= '0;
        else if (wr_done && wr_addr == 7'(gi)) q_reg <= shift_reg[7:0];
      end
      assign reg_vals[gi] = q_reg;
    end
  endgenerate

  assign en_reg_out_7_0  = reg_vals[0];
  assign en_reg_out_15_8 = reg_vals[1];
  assign en_reg_pwm_7_0  = reg_vals[2];
  assign en_reg_pwm_15_8 = reg_vals[3];
  assign pwm_duty_cycle  = reg_vals[4];

`ifdef SPI_READBACK_EN
  logic       sclk_fall, rd_ok;
  logic [6:0] rd_addr;
  logic [7:0] out_shift_reg;
  logic       cipo_reg;

  assign sclk_fall = ~sclk_sync_reg[1] & sclk_sync_reg[2];
  // Address as it will stand after the 8th shift; the R/W bit lands in shift_reg[6]->[7].
  assign rd_addr   = {shift_reg[5:0], copi_bit};
  assign rd_ok     = (rd_addr <= MAX_A) && (rd_addr < 7'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_shift_reg <= '0;
      cipo_reg      <= 1'b0;
    end else if (state_reg != SHIFT || ncs_rise) begin
      out_shift_reg <= '0;
      cipo_reg      <= 1'b0;
    end else if (sclk_rise && cnt_reg == 5'd7 && !shift_reg[6]) begin
      out_shift_reg <= rd_ok ? reg_vals[rd_addr[2:0]] : 8'h00;
    end else if (sclk_fall) begin
      cipo_reg      <= out_shift_reg[7];
      out_shift_reg <= {out_shift_reg[6:0], 1'b0};
    end
  end

  assign cipo = cipo_reg;
`else
  assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: drives SPI frames at clk/8 and checks registers and pulses.
module tb_spi_reg_ctrl;
  logic       clk = 1'b0, rst = 1'b1, sclk = 1'b0, copi = 1'b0, ncs = 1'b1;
  logic       cipo, wr_done, frame_err;
  logic [7:0] out70, out158, pwm70, pwm158, duty;
  int         pass_cnt = 0, check_cnt = 0;
  int         wr_total = 0, err_total = 0;
  logic [15:0] cap;

  spi_reg_ctrl #(.MAX_ADDR(4)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs), .cipo(cipo),
    .en_reg_out_7_0(out70), .en_reg_out_15_8(out158),
    .en_reg_pwm_7_0(pwm70), .en_reg_pwm_15_8(pwm158),
    .pwm_duty_cycle(duty), .wr_done(wr_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  // Cycle counts of the pulse outputs; a one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (wr_done) wr_total++;
    if (frame_err) err_total++;
  end

  task automatic shift_bits(input logic [15:0] d, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      copi = (i < 16) ? d[15-i] : 1'b0;
      #40;
      if (i < 16) cap[15-i] = cipo;
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [15:0] d, input int n);
    ncs = 1'b0;
    cap = '0;
    #40;
    shift_bits(d, 0, n);
    #40;
    ncs = 1'b1;
    copi = 1'b0;
    $display("frame %h bits %0d", d, n);
  endtask

  task automatic settle();
    repeat (12) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (4) @(negedge clk);
    check_cnt++; if ({out70, out158, pwm70, pwm158, duty} !== 40'h0) $display("FAIL reset_regs: got %h want 0", {out70, out158, pwm70, pwm158, duty}); else pass_cnt++;
    check_cnt++; if (cipo !== 1'b0) $display("FAIL reset_cipo: got %b want 0", cipo); else pass_cnt++;
    check_cnt++; if (wr_done !== 1'b0) $display("FAIL reset_wr_done: got %b want 0", wr_done); else pass_cnt++;
    check_cnt++; if (frame_err !== 1'b0) $display("FAIL reset_frame_err: got %b want 0", frame_err); else pass_cnt++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write_out();
    int w0, e0;
    w0 = wr_total; e0 = err_total;
    frame(16'h80FF, 16);
    settle();
    check_cnt++; if (out70 !== 8'hFF) $display("FAIL write_out70: got %h want ff", out70); else pass_cnt++;
    check_cnt++; if ({out158, pwm70, pwm158, duty} !== 32'h0) $display("FAIL write_others: got %h want 0", {out158, pwm70, pwm158, duty}); else pass_cnt++;
    check_cnt++; if (wr_total - w0 !== 1) $display("FAIL write_wr_done: got %0d pulses want 1", wr_total - w0); else pass_cnt++;
    check_cnt++; if (err_total - e0 !== 0) $display("FAIL write_frame_err: got %0d pulses want 0", err_total - e0); else pass_cnt++;
  endtask

  task automatic test_pwm_timing();
    int k;
    frame(16'h8480, 16);
    for (k = 0; k < 20 && wr_done !== 1'b1; k++) @(negedge clk);
    check_cnt++; if (wr_done !== 1'b1) $display("FAIL pwm_commit_timeout: got %b want 1", wr_done); else pass_cnt++;
    check_cnt++; if (duty !== 8'h00) $display("FAIL pwm_during_commit: got %h want 00", duty); else pass_cnt++;
    @(negedge clk);
    check_cnt++; if (duty !== 8'h80) $display("FAIL pwm_after_commit: got %h want 80", duty); else pass_cnt++;
    check_cnt++; if (wr_done !== 1'b0) $display("FAIL pwm_pulse_width: got %b want 0", wr_done); else pass_cnt++;
    settle();
  endtask

  task automatic test_bad_addr();
    int w0, e0;
    w0 = wr_total; e0 = err_total;
    frame(16'h85AA, 16);
    settle();
    check_cnt++; if ({out70, out158, pwm70, pwm158, duty} !== 40'hFF00000080) $display("FAIL bad_addr_regs: got %h want ff00000080", {out70, out158, pwm70, pwm158, duty}); else pass_cnt++;
    check_cnt++; if (wr_total - w0 !== 0) $display("FAIL bad_addr_wr_done: got %0d want 0", wr_total - w0); else pass_cnt++;
    check_cnt++; if (err_total - e0 !== 0) $display("FAIL bad_addr_frame_err: got %0d want 0", err_total - e0); else pass_cnt++;
  endtask

  task automatic test_frame_err();
    int w0, e0;
    do_reset();
    check_cnt++; if ({out70, duty} !== 16'h0) $display("FAIL rst_clears_regs: got %h want 0", {out70, duty}); else pass_cnt++;
    w0 = wr_total; e0 = err_total;
    frame(16'h80FF, 15);
    settle();
    check_cnt++; if (err_total - e0 !== 1) $display("FAIL short_frame_err: got %0d want 1", err_total - e0); else pass_cnt++;
    check_cnt++; if (out70 !== 8'h00) $display("FAIL short_frame_reg: got %h want 00", out70); else pass_cnt++;
    e0 = err_total;
    frame(16'h80FF, 17);
    settle();
    check_cnt++; if (err_total - e0 !== 1) $display("FAIL long_frame_err: got %0d want 1", err_total - e0); else pass_cnt++;
    check_cnt++; if (out70 !== 8'h00) $display("FAIL long_frame_reg: got %h want 00", out70); else pass_cnt++;
    check_cnt++; if (wr_total - w0 !== 0) $display("FAIL bad_frames_wr_done: got %0d want 0", wr_total - w0); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int w0, e0;
    ncs = 1'b0;
    #40;
    shift_bits(16'h8355, 0, 10);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    w0 = wr_total; e0 = err_total;
    shift_bits(16'h8355, 10, 6);
    #40;
    ncs = 1'b1;
    settle();
    frame(16'h8333, 16);
    settle();
    check_cnt++; if (pwm158 !== 8'h33) $display("FAIL abort_pwm158: got %h want 33", pwm158); else pass_cnt++;
    check_cnt++; if ({out70, out158, pwm70, duty} !== 32'h0) $display("FAIL abort_others: got %h want 0", {out70, out158, pwm70, duty}); else pass_cnt++;
    check_cnt++; if (wr_total - w0 !== 1) $display("FAIL abort_wr_done: got %0d want 1", wr_total - w0); else pass_cnt++;
    check_cnt++; if (err_total - e0 !== 0) $display("FAIL abort_frame_err: got %0d want 0", err_total - e0); else pass_cnt++;
  endtask

  task automatic test_readback();
    int w0, e0;
    logic [15:0] exp_cap;
`ifdef SPI_READBACK_EN
    exp_cap = 16'h0080;
`else
    exp_cap = 16'h0000;
`endif
    w0 = wr_total; e0 = err_total;
    frame(16'h8480, 16);
    settle();
    frame(16'h0400, 16);
    check_cnt++; if (cap !== exp_cap) $display("FAIL readback_cipo: got %h want %h", cap, exp_cap); else pass_cnt++;
    settle();
    check_cnt++; if (cipo !== 1'b0) $display("FAIL readback_cipo_idle: got %b want 0", cipo); else pass_cnt++;
    frame(16'h0500, 16);
    check_cnt++; if (cap !== 16'h0000) $display("FAIL readback_bad_addr: got %h want 0000", cap); else pass_cnt++;
    settle();
    check_cnt++; if (duty !== 8'h80) $display("FAIL readback_duty: got %h want 80", duty); else pass_cnt++;
    check_cnt++; if (wr_total - w0 !== 1) $display("FAIL readback_wr_done: got %0d want 1", wr_total - w0); else pass_cnt++;
    check_cnt++; if (err_total - e0 !== 0) $display("FAIL readback_frame_err: got %0d want 0", err_total - e0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int w0;
    w0 = wr_total;
    frame(16'h8112, 16);
    #40;
    frame(16'h8234, 16);
    settle();
    check_cnt++; if (out158 !== 8'h12) $display("FAIL b2b_out158: got %h want 12", out158); else pass_cnt++;
    check_cnt++; if (pwm70 !== 8'h34) $display("FAIL b2b_pwm70: got %h want 34", pwm70); else pass_cnt++;
    check_cnt++; if (wr_total - w0 !== 2) $display("FAIL b2b_wr_done: got %0d want 2", wr_total - w0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_out();
    test_pwm_timing();
    test_bad_addr();
    test_frame_err();
    test_reset_abort();
    test_readback();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
